// File: rtl/bg_tile_fetcher.sv
// rtl/bg_tile_fetcher.sv - background tile fetch and 16-bit pixel shift stage
//
// Purpose: on each line_start, fetches 34 tiles (nametable index, attribute
// byte, low and high bitplanes) and streams 256 four-bit palette indices
// per line to the pixel output stage over a valid/ready handshake.
//
// Ports:
//   CLOCK_24                       only clock
//   RESET                          asynchronous active-high reset
//   line_start                     one-cycle pulse, starts or restarts a line
//   line, fine_x, chr_table        line parameters, sampled on line_start
//   nt_addr / nt_data              nametable RAM read, data 1 cycle after address
//   chr_addr / chr_data            pattern ROM read, data 1 cycle after address
//   pix_valid, pix_ready           pixel handshake
//   pix_color                      {attr[1:0], hi_bit, lo_bit}
//   pix_x                          x coordinate of the presented pixel
//   line_done                      pulse after pixel 255 is accepted
module bg_tile_fetcher #(
    parameter int CHR_AW = 13,
    parameter int NT_AW  = 10
) (
    input  logic              CLOCK_24,
    input  logic              RESET,
    input  logic              line_start,
    input  logic [7:0]        line,
    input  logic [2:0]        fine_x,
    input  logic              chr_table,
    output logic [NT_AW-1:0]  nt_addr,
    input  logic [7:0]        nt_data,
    output logic [CHR_AW-1:0] chr_addr,
    input  logic [7:0]        chr_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [3:0]        pix_color,
    output logic [7:0]        pix_x,
    output logic              line_done
);

    typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [7:0]          r_line;
    logic [2:0]          r_fine_x;
    logic                r_chr_table;
    logic [4:0]          r_tile_x;
    logic [2:0]          r_step;
    logic [7:0]          r_pix_x;
    logic                r_fresh;
    logic [7:0]          r_tile;
    logic [1:0]          r_attr;
    logic [7:0]          r_lo;
    logic [7:0]          r_hi;
    logic [15:0]         r_lo_sh;
    logic [15:0]         r_hi_sh;
    logic [15:0]         r_at0_sh;
    logic [15:0]         r_at1_sh;
    logic [NT_AW-1:0]    r_nt_addr;
    logic [CHR_AW-1:0]   r_chr_addr;
    logic                r_line_done;

    logic                w_accept;
    logic                w_advance;
    logic                w_last;
    logic                w_load;
    logic [3:0]          w_bit;
    logic [4:0]          w_tile_x_nxt;
    logic [7:0]          w_attr_byte;

    // Prefetch loads append the new tile below the previous one; in RUN the
    // shifter moves left one bit per accept and the new tile lands in the
    // freshly vacated low byte.
    function automatic logic [15:0] sh_next(input logic [15:0] sh,
                                            input logic [7:0]  new_byte,
                                            input logic        shift,
                                            input logic        load);
        logic [15:0] v;
        v = shift ? {sh[14:0], 1'b0} : sh;
        if (load) begin
            v = shift ? {sh[14:7], new_byte} : {sh[7:0], new_byte};
        end
        return v;
    endfunction

    always_ff @(posedge CLOCK_24 or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_PREFETCH: begin
                w_advance = 1'b1;
                if (r_step == 3'd7 && r_tile_x == 5'd1) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_accept  = pix_ready;
                w_advance = pix_ready;
                w_last    = pix_ready && (r_pix_x == 8'd255);
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: ;
        endcase
        // A new line_start wins over everything, including a final accept.
        if (line_start) begin
            w_state_nxt = S_PREFETCH;
            w_accept    = 1'b0;
            w_advance   = 1'b0;
            w_last      = 1'b0;
        end
    end

    assign w_load       = (r_step == 3'd7);
    assign w_tile_x_nxt = r_tile_x + 5'd1;
    assign w_attr_byte  = nt_data >> {r_line[4], r_tile_x[1], 1'b0};

    always_ff @(posedge CLOCK_24 or posedge RESET) begin
        if (RESET) begin
            r_line      <= '0;
            r_fine_x    <= '0;
            r_chr_table <= 1'b0;
            r_tile_x    <= '0;
            r_step      <= '0;
            r_pix_x     <= '0;
            r_fresh     <= 1'b0;
            r_tile      <= '0;
            r_attr      <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_lo_sh     <= '0;
            r_hi_sh     <= '0;
            r_at0_sh    <= '0;
            r_at1_sh    <= '0;
            r_nt_addr   <= '0;
            r_chr_addr  <= '0;
            r_line_done <= 1'b0;
        end else begin
            r_line_done <= w_last;
            // Memory data reflects the address of the previous cycle, which is
            // the previous step's address only on the first cycle of a step.
            // Capturing there alone keeps stalled steps from picking up data
            // for the address that the current step already presents.
            r_fresh     <= line_start | w_advance;
            if (line_start) begin
                r_line      <= line;
                r_fine_x    <= fine_x;
                r_chr_table <= chr_table;
                r_tile_x    <= '0;
                r_step      <= '0;
                r_pix_x     <= '0;
                r_nt_addr   <= NT_AW'({line[7:3], 5'd0});
            end else begin
                if (r_fresh && r_state != S_IDLE) begin
                    case (r_step)
                        3'd1:    r_tile <= nt_data;
                        3'd2:    r_attr <= w_attr_byte[1:0];
                        3'd4:    r_lo   <= chr_data;
                        3'd6:    r_hi   <= chr_data;
                        default: ;
                    endcase
                end
                if (w_advance) begin
                    r_step <= r_step + 3'd1;
                    case (r_step)
                        3'd0: r_nt_addr  <= NT_AW'(10'h3C0 + {4'd0, r_line[7:5], r_tile_x[4:2]});
                        3'd2: r_chr_addr <= CHR_AW'({r_chr_table, r_tile, 1'b0, r_line[2:0]});
                        3'd3: r_chr_addr <= r_chr_addr + CHR_AW'(8);
                        3'd7: begin
                            r_tile_x  <= w_tile_x_nxt;
                            r_nt_addr <= NT_AW'({r_line[7:3], w_tile_x_nxt});
                        end
                        default: ;
                    endcase
                    r_lo_sh  <= sh_next(r_lo_sh,  r_lo,             w_accept, w_load);
                    r_hi_sh  <= sh_next(r_hi_sh,  r_hi,             w_accept, w_load);
                    r_at0_sh <= sh_next(r_at0_sh, {8{r_attr[0]}},   w_accept, w_load);
                    r_at1_sh <= sh_next(r_at1_sh, {8{r_attr[1]}},   w_accept, w_load);
                end
                if (w_accept) begin
                    r_pix_x <= r_pix_x + 8'd1;
                end
            end
        end
    end

    assign w_bit     = 4'd15 - {1'b0, r_fine_x};
    assign pix_valid = (r_state == S_RUN);
    assign pix_color = pix_valid ? {r_at1_sh[w_bit], r_at0_sh[w_bit], r_hi_sh[w_bit], r_lo_sh[w_bit]}
                                 : 4'd0;
    assign pix_x     = r_pix_x;
    assign nt_addr   = r_nt_addr;
    assign chr_addr  = r_chr_addr;
    assign line_done = r_line_done;

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// tb/tb_bg_tile_fetcher.sv - directed self-checking bench for bg_tile_fetcher
module tb_bg_tile_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [7:0]  line;
    logic [2:0]  fine_x;
    logic        chr_table;
    logic [9:0]  nt_addr;
    logic [7:0]  nt_data;
    logic [12:0] chr_addr;
    logic [7:0]  chr_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [3:0]  pix_color;
    logic [7:0]  pix_x;
    logic        line_done;

    always #5 clk = ~clk;

    bg_tile_fetcher #(.CHR_AW(13), .NT_AW(10)) dut (
        .CLOCK_24  (clk),
        .RESET     (rst),
        .line_start(line_start),
        .line      (line),
        .fine_x    (fine_x),
        .chr_table (chr_table),
        .nt_addr   (nt_addr),
        .nt_data   (nt_data),
        .chr_addr  (chr_addr),
        .chr_data  (chr_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_color (pix_color),
        .pix_x     (pix_x),
        .line_done (line_done)
    );

    logic [7:0] nt_mem  [0:1023];
    logic [7:0] chr_mem [0:8191];

    always @(posedge clk) begin
        nt_data  <= nt_mem[nt_addr];
        chr_data <= chr_mem[chr_addr];
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [3:0] px     [0:255];
    logic [3:0] ref_px [0:255];
    logic [3:0] t1_pat [0:7];

    int t_valid, t_done, n_acc, last_col, addr_bad, order_bad, stall_cnt;
    logic v_at_done;

    task automatic run_line(input logic [7:0] ln, input logic [2:0] fx,
                            input int ready_pct, input int abort_px);
        int t;
        bit aborted;
        bit prev_stall;
        logic [9:0]  prev_nt;
        logic [12:0] prev_chr;
        t_valid = -1; t_done = -1; n_acc = 0; last_col = -1;
        addr_bad = 0; order_bad = 0; stall_cnt = 0; v_at_done = 1'bx;
        aborted = 0; prev_stall = 0; prev_nt = '0; prev_chr = '0;
        @(negedge clk);
        line = ln; fine_x = fx; chr_table = 1'b0; line_start = 1'b1; pix_ready = 1'b1;
        t = 0;
        for (int k = 0; k < 3000 && t_done < 0; k++) begin
            @(negedge clk);
            line_start = 1'b0;
            t++;
            pix_ready = ($urandom_range(99) < ready_pct);
            if (prev_stall && (nt_addr !== prev_nt || chr_addr !== prev_chr)) addr_bad++;
            if (line_done) begin
                t_done    = t;
                v_at_done = pix_valid;
            end
            if (pix_valid && t_valid < 0) t_valid = t;
            if (pix_valid && nt_addr < 10'h3C0) last_col = int'(nt_addr[4:0]);
            if (pix_valid && abort_px >= 0 && !aborted && int'(pix_x) == abort_px) begin
                aborted = 1; line_start = 1'b1; t = 0; n_acc = 0;
                t_valid = -1; last_col = -1; prev_stall = 0; stall_cnt = 0;
            end else begin
                if (pix_valid && pix_ready) begin
                    if (pix_x !== n_acc[7:0]) order_bad++;
                    if (n_acc < 256) px[n_acc] = pix_color;
                    n_acc++;
                end
                prev_stall = pix_valid && !pix_ready;
                if (prev_stall) stall_cnt++;
            end
            prev_nt  = nt_addr;
            prev_chr = chr_addr;
        end
        pix_ready = 1'b1;
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_pix_valid"}, 32'(pix_valid), 0);
        check_eq({pfx, "_pix_color"}, 32'(pix_color), 0);
        check_eq({pfx, "_pix_x"},     32'(pix_x),     0);
        check_eq({pfx, "_nt_addr"},   32'(nt_addr),   0);
        check_eq({pfx, "_chr_addr"},  32'(chr_addr),  0);
        check_eq({pfx, "_line_done"}, 32'(line_done), 0);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 1024; i++) nt_mem[i] = 8'h00;
        for (int i = 0; i < 8192; i++) chr_mem[i] = 8'h00;
        nt_mem[0]       = 8'h01;
        nt_mem[1]       = 8'h02;
        nt_mem[64]      = 8'h01;
        nt_mem[10'h3C0] = 8'hE4;
        chr_mem[13'h0010] = 8'hFF;
        chr_mem[13'h0018] = 8'h00;
        chr_mem[13'h0020] = 8'hA5;
        chr_mem[13'h0028] = 8'h0F;
        t1_pat = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h2, 4'h3, 4'h2, 4'h3};

        rst = 1'b1; line_start = 1'b0; line = '0; fine_x = '0; chr_table = 1'b0; pix_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("rst");
        rst = 1'b0;
        @(negedge clk);

        // Line 0, no scroll, no stalls
        run_line(8'd0, 3'd0, 100, -1);
        check_eq("a_t_valid", t_valid, 17);
        check_eq("a_t_done", t_done, 273);
        check_eq("a_valid_at_done", 32'(v_at_done), 0);
        check_eq("a_n_acc", n_acc, 256);
        check_eq("a_order", order_bad, 0);
        for (int i = 0; i < 8; i++) check_eq($sformatf("a_px%0d", i), 32'(px[i]), 1);
        for (int i = 0; i < 8; i++) check_eq($sformatf("a_px%0d", 8 + i), 32'(px[8 + i]), 32'(t1_pat[i]));
        check_eq("a_px16", 32'(px[16]), 4);
        check_eq("a_px31", 32'(px[31]), 4);
        check_eq("a_px32", 32'(px[32]), 0);
        check_eq("a_px255", 32'(px[255]), 0);
        @(negedge clk);
        check_eq("a_done_pulse_width", 32'(line_done), 0);

        // Line 0, fine_x = 3
        run_line(8'd0, 3'd3, 100, -1);
        check_eq("b_t_valid", t_valid, 17);
        check_eq("b_t_done", t_done, 273);
        for (int i = 0; i < 5; i++) check_eq($sformatf("b_px%0d", i), 32'(px[i]), 1);
        for (int i = 0; i < 8; i++) check_eq($sformatf("b_px%0d", 5 + i), 32'(px[5 + i]), 32'(t1_pat[i]));
        check_eq("b_px13", 32'(px[13]), 4);
        check_eq("b_px28", 32'(px[28]), 4);
        check_eq("b_px29", 32'(px[29]), 0);
        check_eq("b_px252", 32'(px[252]), 0);
        check_eq("b_px253", 32'(px[253]), 1);
        check_eq("b_px255", 32'(px[255]), 1);
        check_eq("b_last_col", last_col, 1);
        for (int i = 0; i < 256; i++) ref_px[i] = px[i];

        // Line 16: lower half of the attribute quadrant
        run_line(8'd16, 3'd0, 100, -1);
        check_eq("c_px0", 32'(px[0]), 9);
        check_eq("c_px7", 32'(px[7]), 9);
        check_eq("c_px8", 32'(px[8]), 8);
        check_eq("c_px16", 32'(px[16]), 12);
        check_eq("c_px24", 32'(px[24]), 12);
        check_eq("c_px32", 32'(px[32]), 0);

        // Random 40% back-pressure must not change the stream
        run_line(8'd0, 3'd3, 60, -1);
        check_eq("d_n_acc", n_acc, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (px[i] !== ref_px[i]) bad++;
        check_eq("d_stream_diff", bad, 0);
        check_eq("d_addr_hold", addr_bad, 0);
        check_eq("d_order", order_bad, 0);
        check_eq("d_t_done", t_done, 273 + stall_cnt);

        // Abort at pix_x = 100, then a normal line follows
        run_line(8'd0, 3'd0, 100, 100);
        check_eq("e_t_valid", t_valid, 17);
        check_eq("e_t_done", t_done, 273);
        check_eq("e_n_acc", n_acc, 256);
        check_eq("e_px0", 32'(px[0]), 1);
        check_eq("e_px12", 32'(px[12]), 2);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        line = 8'd0; fine_x = 3'd0; line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("f_running", 32'(pix_valid), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_outputs_zero("f_async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("f_idle_valid", 32'(pix_valid), 0);
        check_eq("f_idle_pix_x", 32'(pix_x), 0);
        run_line(8'd0, 3'd0, 100, -1);
        check_eq("f_t_valid", t_valid, 17);
        check_eq("f_t_done", t_done, 273);
        check_eq("f_px8", 32'(px[8]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
